// File: rtl/stream_demux16_if.sv
// Handshake bundle between one producer, the demux, and NUM consumers.
interface stream_demux16_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SELW  = 4,
  parameter int unsigned NUM   = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [SELW-1:0]  in_sel;
  logic [WIDTH-1:0] in_data;
  logic [NUM-1:0]   out_valid;
  logic [NUM-1:0]   out_ready;
  logic [WIDTH-1:0] out_data;
  logic [SELW-1:0]  out_sel;
  logic             err;
  logic [7:0]       drop_cnt;

  // Environment side: drives the producer beat and the consumer readies.
  modport master (
    output in_valid, in_sel, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel, err, drop_cnt
  );

  // Demux side.
  modport slave (
    input  in_valid, in_sel, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel, err, drop_cnt
  );
endinterface

// File: rtl/stream_demux16.sv
// Streaming 1-to-NUM demultiplexer with a 2-entry FIFO. Each beat is steered
// to the consumer named by its sel field; out-of-range beats are dropped and
// counted. All outputs come straight from flops.
module stream_demux16 #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SELW  = 4,
  parameter int unsigned NUM   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  stream_demux16_if.slave   bus
);

  localparam logic [SELW:0] NUM_L = (SELW+1)'(NUM);

  logic [SELW-1:0]  mem_sel  [2];
  logic [WIDTH-1:0] mem_data [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       count_q;
  logic             in_ready_q;
  logic [NUM-1:0]   out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [SELW-1:0]  out_sel_q;
  logic             err_q;
  logic [7:0]       drop_cnt_q;

  logic             push_c, in_range_c, wr_c, drop_c, pop_c;
  logic             wr_ptr_nxt, rd_ptr_nxt;
  logic [1:0]       count_nxt;
  logic [NUM-1:0]   out_valid_nxt;
  logic [WIDTH-1:0] out_data_nxt;
  logic [SELW-1:0]  out_sel_nxt;

  // Next FIFO state and the head that will be presented after this edge.
  always_comb begin
    push_c        = bus.in_valid & in_ready_q;
    in_range_c    = ({1'b0, bus.in_sel} < NUM_L);
    wr_c          = push_c & in_range_c;
    drop_c        = push_c & ~in_range_c;
    pop_c         = |(out_valid_q & bus.out_ready);
    wr_ptr_nxt    = wr_ptr_q ^ wr_c;
    rd_ptr_nxt    = rd_ptr_q ^ pop_c;
    count_nxt     = count_q;
    out_valid_nxt = '0;
    out_data_nxt  = '0;
    out_sel_nxt   = '0;
    if (wr_c && !pop_c) begin
      count_nxt = count_q + 2'd1;
    end else if (!wr_c && pop_c) begin
      count_nxt = count_q - 2'd1;
    end
    if (count_nxt != 2'd0) begin
      // A beat written into the slot that becomes head bypasses the memory.
      if (wr_c && (wr_ptr_q == rd_ptr_nxt)) begin
        out_sel_nxt  = bus.in_sel;
        out_data_nxt = bus.in_data;
      end else begin
        out_sel_nxt  = mem_sel[rd_ptr_nxt];
        out_data_nxt = mem_data[rd_ptr_nxt];
      end
      for (int k = 0; k < NUM; k++) begin
        out_valid_nxt[k] = (out_sel_nxt == SELW'(k));
      end
    end
  end

  // FIFO storage, pointers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_sel[0]  <= '0;
      mem_sel[1]  <= '0;
      mem_data[0] <= '0;
      mem_data[1] <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= '0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      err_q       <= 1'b0;
      drop_cnt_q  <= 8'd0;
    end else begin
      if (wr_c) begin
        mem_sel[wr_ptr_q]  <= bus.in_sel;
        mem_data[wr_ptr_q] <= bus.in_data;
      end
      wr_ptr_q    <= wr_ptr_nxt;
      rd_ptr_q    <= rd_ptr_nxt;
      count_q     <= count_nxt;
      in_ready_q  <= (count_nxt != 2'd2);
      out_valid_q <= out_valid_nxt;
      out_data_q  <= out_data_nxt;
      out_sel_q   <= out_sel_nxt;
      err_q       <= drop_c;
      if (drop_c && (drop_cnt_q != 8'hFF)) begin
        drop_cnt_q <= drop_cnt_q + 8'd1;
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.err       = err_q;
  assign bus.drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_stream_demux16.sv
// Directed bench for stream_demux16: a NUM=16 and a NUM=12 instance.
module tb_stream_demux16;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  stream_demux16_if #(.WIDTH(32), .SELW(4), .NUM(16)) ifa ();
  stream_demux16_if #(.WIDTH(32), .SELW(4), .NUM(12)) ifb ();

  stream_demux16 #(.WIDTH(32), .SELW(4), .NUM(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa)
  );
  stream_demux16 #(.WIDTH(32), .SELW(4), .NUM(12)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ifa.in_valid = 1'b0; ifa.in_sel = '0; ifa.in_data = '0; ifa.out_ready = '0;
    ifb.in_valid = 1'b0; ifb.in_sel = '0; ifb.in_data = '0; ifb.out_ready = '0;
    tick(); tick();
    n_checks++;
    if (ifa.out_valid !== 16'h0 || ifa.out_data !== 32'h0 || ifa.out_sel !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_out: valid=%h data=%h sel=%h, want 0/0/0", ifa.out_valid, ifa.out_data, ifa.out_sel);
    end
    n_checks++;
    if (ifa.err !== 1'b0 || ifa.drop_cnt !== 8'd0 || ifb.drop_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_err: err=%b drop_a=%0d drop_b=%0d, want 0", ifa.err, ifa.drop_cnt, ifb.drop_cnt);
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (ifa.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b want 1", ifa.in_ready);
    end
  endtask

  task automatic test_single();
    ifa.out_ready = 16'hFFFF;
    ifa.in_valid = 1'b1; ifa.in_sel = 4'd3; ifa.in_data = 32'hDEADBEEF;
    tick();
    ifa.in_valid = 1'b0;
    n_checks++;
    if (ifa.out_valid !== 16'h0008 || ifa.out_data !== 32'hDEADBEEF || ifa.out_sel !== 4'd3) begin
      n_fail++;
      $display("FAIL single_head: valid=%h data=%h sel=%h, want 0008/deadbeef/3", ifa.out_valid, ifa.out_data, ifa.out_sel);
    end
    tick();
    n_checks++;
    if (ifa.out_valid !== 16'h0 || ifa.out_data !== 32'h0 || ifa.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL single_drain: valid=%h data=%h in_ready=%b, want 0/0/1", ifa.out_valid, ifa.out_data, ifa.in_ready);
    end
  endtask

  task automatic test_backpressure();
    ifa.out_ready = 16'h0;
    ifa.in_valid = 1'b1; ifa.in_sel = 4'd5; ifa.in_data = 32'h11;
    tick();
    ifa.in_sel = 4'd9; ifa.in_data = 32'h22;
    tick();
    ifa.in_valid = 1'b0;
    n_checks++;
    if (ifa.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_full: in_ready=%b want 0", ifa.in_ready);
    end
    for (int c = 0; c < 10; c++) begin
      n_checks++;
      if (ifa.out_valid !== 16'h0020 || ifa.out_data !== 32'h11 || ifa.out_sel !== 4'd5) begin
        n_fail++;
        $display("FAIL bp_hold_first cyc%0d: valid=%h data=%h sel=%h, want 0020/11/5", c, ifa.out_valid, ifa.out_data, ifa.out_sel);
      end
      tick();
    end
    ifa.out_ready = 16'h0020;
    tick();
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (ifa.out_valid !== 16'h0200 || ifa.out_data !== 32'h22 || ifa.in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_second cyc%0d: valid=%h data=%h in_ready=%b, want 0200/22/1", c, ifa.out_valid, ifa.out_data, ifa.in_ready);
      end
      tick();
    end
    ifa.out_ready = 16'h0200;
    tick();
    n_checks++;
    if (ifa.out_valid !== 16'h0) begin
      n_fail++;
      $display("FAIL bp_drain: valid=%h want 0", ifa.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_v;
    ifa.out_ready = 16'hFFFF;
    for (int i = 0; i < 32; i++) begin
      ifa.in_valid = 1'b1; ifa.in_sel = 4'(i % 16); ifa.in_data = 32'(i);
      tick();
      exp_v = 16'h1 << (i % 16);
      n_checks++;
      if (ifa.in_ready !== 1'b1 || ifa.out_valid !== exp_v || ifa.out_data !== 32'(i)) begin
        n_fail++;
        $display("FAIL stream beat%0d: in_ready=%b valid=%h data=%h, want 1/%h/%h", i, ifa.in_ready, ifa.out_valid, ifa.out_data, exp_v, i);
      end
    end
    ifa.in_valid = 1'b0;
    tick();
    n_checks++;
    if (ifa.out_valid !== 16'h0) begin
      n_fail++;
      $display("FAIL stream_drain: valid=%h want 0", ifa.out_valid);
    end
  endtask

  task automatic test_wrong_ready();
    ifa.out_ready = 16'h0;
    ifa.in_valid = 1'b1; ifa.in_sel = 4'd2; ifa.in_data = 32'hA5A5;
    tick();
    ifa.in_valid = 1'b0;
    ifa.out_ready = 16'hFFFB;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if (ifa.out_valid !== 16'h0004 || ifa.out_data !== 32'hA5A5) begin
        n_fail++;
        $display("FAIL wrong_ready cyc%0d: valid=%h data=%h, want 0004/a5a5", c, ifa.out_valid, ifa.out_data);
      end
    end
    ifa.out_ready = 16'h0004;
    tick();
    n_checks++;
    if (ifa.out_valid !== 16'h0) begin
      n_fail++;
      $display("FAIL wrong_ready_pop: valid=%h want 0", ifa.out_valid);
    end
  endtask

  task automatic test_drop();
    ifb.out_ready = 12'hFFF;
    ifb.in_valid = 1'b1; ifb.in_sel = 4'd13; ifb.in_data = 32'hBAD;
    tick();
    ifb.in_valid = 1'b0;
    n_checks++;
    if (ifb.err !== 1'b1 || ifb.drop_cnt !== 8'd1 || ifb.out_valid !== 12'h0 || ifb.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_first: err=%b cnt=%0d valid=%h in_ready=%b, want 1/1/000/1", ifb.err, ifb.drop_cnt, ifb.out_valid, ifb.in_ready);
    end
    tick();
    n_checks++;
    if (ifb.err !== 1'b0 || ifb.drop_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL drop_pulse_end: err=%b cnt=%0d, want 0/1", ifb.err, ifb.drop_cnt);
    end
    // sel=11 is the highest legal destination
    ifb.in_valid = 1'b1; ifb.in_sel = 4'd11; ifb.in_data = 32'h77;
    tick();
    n_checks++;
    if (ifb.out_valid !== 12'h800 || ifb.out_data !== 32'h77 || ifb.err !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_edge_ok: valid=%h data=%h err=%b, want 800/77/0", ifb.out_valid, ifb.out_data, ifb.err);
    end
    // sel=12 == NUM is dropped while the head pops
    ifb.in_sel = 4'd12; ifb.in_data = 32'h88;
    tick();
    ifb.in_valid = 1'b0;
    n_checks++;
    if (ifb.out_valid !== 12'h0 || ifb.err !== 1'b1 || ifb.drop_cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL drop_with_pop: valid=%h err=%b cnt=%0d, want 000/1/2", ifb.out_valid, ifb.err, ifb.drop_cnt);
    end
    ifb.in_valid = 1'b1; ifb.in_sel = 4'd15;
    for (int c = 0; c < 300; c++) tick();
    ifb.in_valid = 1'b0;
    tick();
    n_checks++;
    if (ifb.drop_cnt !== 8'd255 || ifb.out_valid !== 12'h0) begin
      n_fail++;
      $display("FAIL drop_saturate: cnt=%0d valid=%h, want 255/000", ifb.drop_cnt, ifb.out_valid);
    end
  endtask

  task automatic test_reset_mid();
    ifa.out_ready = 16'h0;
    ifa.in_valid = 1'b1; ifa.in_sel = 4'd1; ifa.in_data = 32'h55;
    tick();
    ifa.in_sel = 4'd2; ifa.in_data = 32'h66;
    tick();
    ifa.in_valid = 1'b0;
    n_checks++;
    if (ifa.in_ready !== 1'b0 || ifa.out_valid !== 16'h0002) begin
      n_fail++;
      $display("FAIL rstmid_full: in_ready=%b valid=%h, want 0/0002", ifa.in_ready, ifa.out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (ifa.out_valid !== 16'h0 || ifa.out_data !== 32'h0) begin
      n_fail++;
      $display("FAIL rstmid_async: valid=%h data=%h, want 0/0", ifa.out_valid, ifa.out_data);
    end
    tick();
    rst_n = 1'b1;
    ifa.out_ready = 16'hFFFF;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_checks++;
      if (ifa.out_valid !== 16'h0 || ifa.in_ready !== 1'b1 || ifb.drop_cnt !== 8'd0) begin
        n_fail++;
        $display("FAIL rstmid_after cyc%0d: valid=%h in_ready=%b drop_b=%0d, want 0/1/0", c, ifa.out_valid, ifa.in_ready, ifb.drop_cnt);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_wrong_ready();
    test_drop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
